// File: rtl/mem_loader.sv
// Boot-time program loader: decodes a little-endian word-count header from a byte
// stream, then packs little-endian words and writes them to SRAM starting at BASE.
module mem_loader #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned BASE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wd,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   // Words that fit between BASE and the top of the address space.
   localparam logic [32:0]       CAPACITY  = (33'd1 << ADDR_W) - 33'(BASE);
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

   state_t            state;
   state_t            state_next;
   logic [1:0]        byte_idx;
   logic [31:0]       count;
   logic [ADDR_W:0]   word_idx;
   logic [ADDR_W:0]   word_idx_inc;
   logic [31:0]       shift;
   logic [31:0]       merged;
   logic              accept;
   logic              last_byte;

   // Ready is a pure function of state so it never waits on in_valid.
   assign in_ready     = (state == S_HDR) || (state == S_DATA);
   assign accept       = in_valid && in_ready;
   assign last_byte    = (byte_idx == 2'd3);
   assign word_idx_inc = word_idx + (ADDR_W+1)'(1);

   // The accumulator with the incoming byte already dropped into its lane.
   always_comb begin
      merged = shift;
      merged[{byte_idx, 3'b000} +: 8] = in_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= S_HDR;
      else       state <= state_next;
   end

   // NOTE: every output and next-state gets a default before the case, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      unique case (state)
         S_HDR: begin
            busy = 1'b1;
            if (accept && last_byte) begin
               if (merged == 32'd0)                 state_next = S_DONE;
               else if ({1'b0, merged} > CAPACITY)  state_next = S_ERR;
               else                                 state_next = S_DATA;
            end
         end
         S_DATA: begin
            busy = 1'b1;
            if (accept && last_byte) state_next = S_WRITE;
         end
         S_WRITE: begin
            busy   = 1'b1;
            mem_we = 1'b1;
            if (32'(word_idx_inc) == count) state_next = S_DONE;
            else                            state_next = S_DATA;
         end
         S_DONE:  done = 1'b1;
         S_ERR:   err  = 1'b1;
         default: state_next = S_HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx <= 2'd0;
         count    <= 32'd0;
         word_idx <= '0;
         shift    <= 32'd0;
         mem_addr <= BASE_ADDR;
         mem_wd   <= 32'd0;
      end else begin
         if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            shift    <= merged;
            if (last_byte) begin
               if (state == S_HDR) begin
                  count    <= merged;
                  word_idx <= '0;
               end else begin
                  // Address and data are presented for the whole WRITE cycle.
                  mem_wd   <= merged;
                  mem_addr <= BASE_ADDR + word_idx[ADDR_W-1:0];
               end
            end
         end
         if (state == S_WRITE) word_idx <= word_idx_inc;
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: header table, directed corner sequences and
// randomized images compared against a byte-stream model of the load.
module tb_mem_loader;

   localparam int unsigned      ADDR_W = 14;
   localparam int unsigned      BASE   = 'h100;
   localparam longint unsigned  CAP    = (longint'(1) << ADDR_W) - BASE;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int                cyc;
   } wr_t;

   typedef struct {
      logic [31:0] count;
      logic        exp_err;
      logic        exp_done;
      logic        exp_ready;
   } hdr_vec_t;

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data  = 8'h00;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [31:0]       mem_wd;
   logic              busy;
   logic              done;
   logic              err;

   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;
   int  accepts  = 0;
   wr_t wr_log[$];

   mem_loader #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_wd   (mem_wd),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Mid-cycle observer: what the SRAM and the source see at the next edge.
   always @(negedge clk) begin
      wr_t w;
      if (mem_we) begin
         w.addr = mem_addr;
         w.data = mem_wd;
         w.cyc  = cyc;
         wr_log.push_back(w);
      end
      if (!reset && in_valid && in_ready) accepts++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
   endtask

   // mode 0: valid every cycle, 1: valid alternating 1-0-1-0, 2: random gaps.
   task automatic send_bytes(input byte_q_t q, input int mode);
      int i      = 0;
      int budget = 4000;
      bit phase  = 1'b1;
      while (i < q.size() && budget > 0) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = phase;
            default: in_valid = ($urandom_range(9) >= 3);
         endcase
         in_data = q[i];
         @(negedge clk);
         if (in_valid && in_ready) i++;
         tick();
         phase = ~phase;
         budget--;
      end
      in_valid = 1'b0;
      check("send_complete", i, q.size());
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (!(done || err) && n < budget) begin
         tick();
         n++;
      end
      check("end_within_budget", done || err, 1);
   endtask

   function automatic logic [31:0] word_at(input byte_q_t q, input int k);
      return {q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]};
   endfunction

   function automatic byte_q_t hdr_bytes(input logic [31:0] c);
      byte_q_t q;
      q = {c[7:0], c[15:8], c[23:16], c[31:24]};
      return q;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_busy"},     busy,     1);
      check({tag, "_done"},     done,     0);
      check({tag, "_err"},      err,      0);
      check({tag, "_mem_we"},   mem_we,   0);
      check({tag, "_mem_addr"}, mem_addr, BASE);
      check({tag, "_mem_wd"},   mem_wd,   0);
   endtask

   initial begin
      hdr_vec_t hv[7];
      byte_q_t  q;
      byte_q_t  q2;

      hv[0] = '{32'd0,           1'b0, 1'b1, 1'b0};
      hv[1] = '{32'd1,           1'b0, 1'b0, 1'b1};
      hv[2] = '{32'(CAP),        1'b0, 1'b0, 1'b1};
      hv[3] = '{32'(CAP + 1),    1'b1, 1'b0, 1'b0};
      hv[4] = '{32'd16385,       1'b1, 1'b0, 1'b0};
      hv[5] = '{32'hFFFF_FFFF,   1'b1, 1'b0, 1'b0};
      hv[6] = '{32'h8000_0000,   1'b1, 1'b0, 1'b0};

      tick(2);
      reset = 1'b0;
      check_reset_outputs("por");

      // Header decode table: outcome one cycle after the 4th header byte.
      foreach (hv[v]) begin
         do_reset();
         wr_log.delete();
         accepts = 0;
         send_bytes(hdr_bytes(hv[v].count), 0);
         check($sformatf("hdr%0d_err", v),      err,      hv[v].exp_err);
         check($sformatf("hdr%0d_done", v),     done,     hv[v].exp_done);
         check($sformatf("hdr%0d_in_ready", v), in_ready, hv[v].exp_ready);
         check($sformatf("hdr%0d_busy", v),     busy,     hv[v].exp_ready);
         in_valid = 1'b1;
         in_data  = 8'h5A;
         tick(3);
         in_valid = 1'b0;
         check($sformatf("hdr%0d_accepts", v), accepts, hv[v].exp_ready ? 7 : 4);
         check($sformatf("hdr%0d_no_write", v), wr_log.size(), 0);
      end

      // Two-word image, valid always high.
      do_reset();
      wr_log.delete();
      q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_bytes(q, 0);
      check("two_write_we",       mem_we,   1);
      check("two_write_in_ready", in_ready, 0);
      check("two_write_done",     done,     0);
      tick();
      check("two_done",      done,     1);
      check("two_busy",      busy,     0);
      check("two_we_after",  mem_we,   0);
      check("two_addr_hold", mem_addr, BASE + 1);
      check("two_wd_hold",   mem_wd,   32'hDEAD_BEEF);
      check("two_nwrites",   wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         check("two_w0_addr", wr_log[0].addr, BASE);
         check("two_w0_data", wr_log[0].data, 32'h1234_5678);
         check("two_w1_addr", wr_log[1].addr, BASE + 1);
         check("two_w1_data", wr_log[1].data, 32'hDEAD_BEEF);
         check("two_word_spacing", wr_log[1].cyc - wr_log[0].cyc, 5);
      end

      // Empty image.
      do_reset();
      wr_log.delete();
      send_bytes(hdr_bytes(32'd0), 0);
      check("empty_done",     done,     1);
      check("empty_busy",     busy,     0);
      check("empty_in_ready", in_ready, 0);
      tick(3);
      check("empty_no_write", wr_log.size(), 0);

      // Backpressure: alternating valid, then a 5th byte held through WRITE and DONE.
      do_reset();
      wr_log.delete();
      accepts = 0;
      send_bytes(hdr_bytes(32'd1), 0);
      q2 = {8'h44, 8'h33, 8'h22, 8'h11};
      send_bytes(q2, 1);
      in_valid = 1'b1;
      in_data  = 8'h99;
      @(negedge clk);
      check("bp_write_in_ready", in_ready, 0);
      check("bp_write_we",       mem_we,   1);
      tick(5);
      in_valid = 1'b0;
      check("bp_accepts", accepts, 8);
      check("bp_done",    done,    1);
      check("bp_nwrites", wr_log.size(), 1);
      if (wr_log.size() == 1) begin
         check("bp_addr", wr_log[0].addr, BASE);
         check("bp_data", wr_log[0].data, 32'h1122_3344);
      end

      // Reset sampled during WRITE: that write lands, nothing else follows.
      do_reset();
      wr_log.delete();
      q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
      send_bytes(q, 0);
      check("rstw_in_write", mem_we, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("rstw");
      tick(3);
      check("rstw_nwrites", wr_log.size(), 1);
      if (wr_log.size() == 1) check("rstw_data", wr_log[0].data, 32'hCAFE_F00D);

      // Reset mid-load, then a fresh one-word image.
      do_reset();
      wr_log.delete();
      q = {8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_bytes(q, 0);
      do_reset();
      check_reset_outputs("rstmid");
      wr_log.delete();
      q = {8'h01, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      send_bytes(q, 0);
      wait_end(10);
      check("rstmid_done",    done, 1);
      check("rstmid_nwrites", wr_log.size(), 1);
      if (wr_log.size() == 1) begin
         check("rstmid_addr", wr_log[0].addr, BASE);
         check("rstmid_data", wr_log[0].data, 32'hAABB_CCDD);
      end

      // Randomized repeated loads against the stream model.
      for (int it = 0; it < 10; it++) begin
         longint unsigned cnt;
         longint unsigned n_exp;
         bit              exp_err;
         int              mode;
         mode = $urandom_range(0, 2);
         if (it % 4 == 3) cnt = CAP + 1 + $urandom_range(0, 1000);
         else             cnt = $urandom_range(0, 6);
         q = hdr_bytes(32'(cnt));
         exp_err = (cnt > CAP);
         n_exp   = exp_err ? 0 : cnt;
         for (longint unsigned b = 0; b < 4 * n_exp; b++) q.push_back(8'($urandom()));
         do_reset();
         check($sformatf("rnd%0d_done_cleared", it), done, 0);
         check($sformatf("rnd%0d_err_cleared", it),  err,  0);
         wr_log.delete();
         send_bytes(q, mode);
         wait_end(20);
         check($sformatf("rnd%0d_err", it),     err,  exp_err);
         check($sformatf("rnd%0d_done", it),    done, !exp_err);
         check($sformatf("rnd%0d_nwrites", it), wr_log.size(), n_exp);
         for (int k = 0; k < wr_log.size() && k < int'(n_exp); k++) begin
            logic [ADDR_W-1:0] ea;
            ea = ADDR_W'((BASE + k) % (1 << ADDR_W));
            check($sformatf("rnd%0d_w%0d_addr", it, k), wr_log[k].addr, ea);
            check($sformatf("rnd%0d_w%0d_data", it, k), wr_log[k].data, word_at(q, k + 1));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_loader.md
# mem_loader

Boot-time program loader for TinySIMT: the writing end of the word SRAM's single-port write interface. It accepts a byte stream with a valid/ready handshake, such as a UART receiver or a test harness. It decodes a 4-byte little-endian word-count header, then assembles little-endian 32-bit words and writes each one to consecutive SRAM word addresses starting at `BASE`. While loading it asserts `busy`, which holds the core in reset; it raises `done` when the image is complete.

## Interface
- `ADDR_W`, default 14: SRAM word-address width (16K words).
- `BASE`, default 0: first word address written.
- `clk`, input, 1: the single clock; everything is on posedge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: the byte on `in_data` is valid.
- `in_data`, input, 8: stream byte.
- `in_ready`, output, 1: the loader accepts a byte this cycle.
- `mem_addr`, output, ADDR_W: SRAM word address.
- `mem_we`, output, 1: SRAM write enable.
- `mem_wd`, output, 32: SRAM write data.
- `busy`, output, 1: load in progress; drives core reset.
- `done`, output, 1: image fully written; sticky until reset.
- `err`, output, 1: header word count exceeds capacity; sticky until reset.

## Operation
- **States:** HDR, DATA, WRITE, DONE, ERR.
- **Registers:** state, `byte_idx` (2 bits), `count` (32 bits), `word_idx` (ADDR_W+1 bits), `shift` (32 bits).
- **Accept rule:** a byte is accepted when `in_valid && in_ready`. `in_ready` = 1 only in HDR and DATA. It must not depend combinationally on `in_valid`.
- **Byte assembly:** the accepted byte goes into lane `byte_idx`, so the first byte lands in [7:0] (little-endian). `byte_idx` then increments and wraps 3→0.
- **HDR:**
  - The header is the 4 accepted bytes, forming `count`.
  - On the 4th byte: if `count` == 0 → DONE.
  - If `count` > 2^ADDR_W − BASE → ERR.
  - Otherwise → DATA, with `word_idx` = 0.
- **DATA:** on the 4th accepted byte, go to WRITE with the full word latched into `mem_wd`.
- **WRITE** (one cycle only):
  - Outputs: `mem_we` = 1, `mem_addr` = BASE + `word_idx[ADDR_W-1:0]`, `in_ready` = 0.
  - Next: `word_idx`++. If the new `word_idx` == `count` → DONE, else → DATA.
- **DONE:** `done` = 1, `busy` = 0, `in_ready` = 0. Further bytes are not accepted. The loader stays here until reset.
- **ERR:** `err` = 1, `busy` = 0, `done` = 0, `in_ready` = 0. No SRAM write ever occurs. The loader stays here until reset.
- **Outputs:**
  - `mem_we` = (state == WRITE) exactly.
  - `mem_addr` and `mem_wd` hold their last values outside WRITE.
  - `busy` = 1 in HDR, DATA and WRITE.
- **Width rules:**
  - Address arithmetic is modulo 2^ADDR_W. The capacity check guarantees no wrap within a valid image.
  - The `count` comparison is unsigned 32-bit.

## Timing
- **Reset values:**
  - state = HDR, so `in_ready` = 1 the cycle after reset deasserts.
  - `mem_we` = 0, `mem_addr` = BASE, `mem_wd` = 0.
  - `busy` = 1, `done` = 0, `err` = 0.
  - `byte_idx`, `word_idx`, `count`, `shift` = 0.
- **Reset mid-operation:** reset sampled high in any state aborts the load. The next cycle is HDR with all counters cleared. If reset arrives during WRITE, that write still completes on the same edge it is sampled; there is no partial/second write.
- **Throughput:** minimum 5 cycles per word (4 accepts + 1 WRITE). `in_valid` gaps only stretch DATA/HDR.
- **SRAM write timing:** the SRAM captures `mem_wd` at the posedge ending the WRITE cycle.
- **DONE/ERR latency:**
  - `done` rises the cycle after the last WRITE.
  - For `count` == 0, `done` rises the cycle after the 4th header byte.
  - `err` rises the cycle after the 4th header byte.
- **Backpressure:** `in_valid` held high during WRITE/DONE/ERR is not consumed. The source must hold its byte until `in_ready`.

## Test plan
- **Normal two-word image**, BASE=0, stream 02 00 00 00 78 56 34 12 EF BE AD DE with `in_valid` always high:
  - `mem_we` pulses twice: addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF.
  - `done` = 1 one cycle after the 2nd WRITE; `busy` = 0.
- **Empty image**, stream 00 00 00 00:
  - No `mem_we` ever.
  - `done` = 1 on the cycle after the 4th byte.
- **Backpressure and gaps**, BASE=0x100, N=1, `in_valid` toggling 1-0-1-0, plus `in_valid` held high through WRITE:
  - Exactly 4 data bytes are consumed.
  - One write to 0x100; `in_ready` = 0 during WRITE.
  - A 5th byte offered after DONE is never accepted.
- **Capacity overflow**, BASE=0, header 01 40 00 00 (16385 words):
  - `err` = 1 and `busy` = 0 the next cycle.
  - `in_ready` = 0 and no `mem_we` thereafter.
- **Reset mid-load**, N=3, reset asserted for 1 cycle after the 2nd data byte of word 1:
  - Outputs return to reset values.
  - A fresh header 01 00 00 00 plus word AABBCCDD writes 0xAABBCCDD to BASE.
- **Repeated load**: after `done`, assert reset and load a different image. The second image is written from BASE again, and `done`/`err` clear on reset.
